switch_bounce_gen: RTL and testbench

Synthesizable switch-bounce emulator: the driving end of the debounce interface. It turns a clean commanded level into a realistic bouncing switch line (`sw_out`) that feeds the debounce datapath/controlpath pair. It is used for hardware-in-loop checking of the debouncer on the board, and as a stimulus source in benches. Bounce count, spacing, optional pseudo-random jitter and post-bounce settle time are all parameterised.

---
 rtl/switch_bounce_gen.sv | 131 +++++++++++++
 tb/tb_switch_bounce_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_bounce_gen.sv
// Switch-bounce emulator: turns a clean commanded level into a bouncing
// switch line with optional LFSR jitter and a settle period before done.
module switch_bounce_gen #(
  parameter int          BOUNCES = 4,
  parameter int          GAP     = 8,
  parameter bit          JITTER  = 1'b0,
  parameter int          SETTLE  = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic        INIT    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic sw_out,
  output logic busy,
  output logic done_tick
);

  localparam int GW  = $clog2(GAP + 4);
  localparam int RW  = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;
  localparam int SCW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_SETTLE
  } state_t;

  state_t         state_q, state_n;
  logic [15:0]    lfsr_q;
  logic           lfsr_fb;
  logic           sw_q, sw_n;
  logic           tgt_q, tgt_n;
  logic           busy_q, busy_n;
  logic           done_q, done_n;
  logic [GW-1:0]  gap_q, gap_n;
  logic [GW-1:0]  gap_val;
  logic [GW-1:0]  jit;
  logic [RW-1:0]  rem_q, rem_n;
  logic [SCW-1:0] set_q, set_n;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  assign jit     = JITTER ? GW'(lfsr_q[1:0]) : '0;
  assign gap_val = GW'(GAP) + jit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q  <= SEED;
      state_q <= S_IDLE;
      sw_q    <= INIT;
      tgt_q   <= INIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      rem_q   <= '0;
      set_q   <= '0;
    end else begin
      lfsr_q  <= {lfsr_fb, lfsr_q[15:1]};
      state_q <= state_n;
      sw_q    <= sw_n;
      tgt_q   <= tgt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      gap_q   <= gap_n;
      rem_q   <= rem_n;
      set_q   <= set_n;
    end
  end

  always_comb begin
    state_n = state_q;
    sw_n    = sw_q;
    tgt_n   = tgt_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    gap_n   = gap_q;
    rem_n   = rem_q;
    set_n   = set_q;
    unique case (state_q)
      S_IDLE: begin
        if (level_in != sw_q) begin
          tgt_n  = level_in;
          sw_n   = ~sw_q;
          rem_n  = RW'(2 * BOUNCES);
          gap_n  = gap_val;
          busy_n = 1'b1;
          if (BOUNCES > 0) begin
            state_n = S_BOUNCE;
          end else begin
            state_n = S_SETTLE;
            set_n   = SCW'(SETTLE);
          end
        end
      end
      S_BOUNCE: begin
        if (gap_q == GW'(1)) begin
          sw_n  = ~sw_q;
          rem_n = rem_q - RW'(1);
          gap_n = gap_val;
          if (rem_q == RW'(1)) begin
            state_n = S_SETTLE;
            set_n   = SCW'(SETTLE);
          end
        end else begin
          gap_n = gap_q - GW'(1);
        end
      end
      S_SETTLE: begin
        sw_n = tgt_q;
        if (set_q == SCW'(1)) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          set_n = set_q - SCW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign sw_out    = sw_q;
  assign busy      = busy_q;
  assign done_tick = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: three parameterisations,
// per-cycle expected traces from a behavioural model and LFSR reference.
module tb_switch_bounce_gen;

  typedef struct {
    logic sw;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lvl_a = 1'b0, lvl_c = 1'b0, lvl_j = 1'b0;
  logic sw_a, busy_a, done_a;
  logic sw_c, busy_c, done_c;
  logic sw_j, busy_j, done_j;
  logic [15:0] m_lfsr;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .BOUNCES(2), .GAP(3), .JITTER(1'b0), .SETTLE(5),
    .SEED(16'hACE1), .INIT(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .level_in(lvl_a),
    .sw_out(sw_a), .busy(busy_a), .done_tick(done_a)
  );

  switch_bounce_gen #(
    .BOUNCES(0), .GAP(3), .JITTER(1'b0), .SETTLE(4),
    .SEED(16'hACE1), .INIT(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .level_in(lvl_c),
    .sw_out(sw_c), .busy(busy_c), .done_tick(done_c)
  );

  switch_bounce_gen #(
    .BOUNCES(3), .GAP(2), .JITTER(1'b1), .SETTLE(3),
    .SEED(16'hACE1), .INIT(1'b0)
  ) dut_j (
    .clk(clk), .rst(rst), .level_in(lvl_j),
    .sw_out(sw_j), .busy(busy_j), .done_tick(done_j)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  // Expected outputs after edge T0+k for k = 0.., until idle for tail cycles.
  task automatic push_trace(input logic start, input int b, input int g,
                            input int s, input bit jit,
                            input logic [15:0] l0, input int tail);
    exp_t e;
    logic sw;
    logic [15:0] l;
    int rem, t_next, end_t, k;
    sw = ~start;
    l = l0;
    rem = 2 * b;
    end_t = s;
    t_next = g + (jit ? int'(l[1:0]) : 0);
    k = 0;
    forever begin
      if (k > 0 && rem > 0 && k == t_next) begin
        sw = ~sw;
        rem--;
        if (rem == 0) end_t = k + s;
        else t_next = k + g + (jit ? int'(l[1:0]) : 0);
      end
      e.sw = sw;
      e.busy = (rem > 0) || (k < end_t);
      e.done = (rem == 0) && (k == end_t);
      q.push_back(e);
      if (rem == 0 && k >= end_t + tail) break;
      l = lfsr_step(l);
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk += 3;
    if (sw_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_sw got %b exp 0", sw_a);
    end
    if (busy_a !== 1'b0 || busy_c !== 1'b0 || busy_j !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b%b%b exp 000",
                          busy_a, busy_c, busy_j);
    end
    if (done_a !== 1'b0 || done_c !== 1'b0 || done_j !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b%b%b exp 000",
                          done_a, done_c, done_j);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_chk++;
      if ({sw_a, busy_a, done_a} !== 3'b000) begin
        n_fail++; $display("FAIL reset_idle got %b%b%b exp 000",
                            sw_a, busy_a, done_a);
      end
    end
  endtask

  task automatic test_basic(input logic start, input string nm);
    exp_t e;
    int k;
    @(negedge clk);
    lvl_a = ~start;
    push_trace(start, 2, 3, 5, 1'b0, 16'h0, 2);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (sw_a !== e.sw) begin
        n_fail++; $display("FAIL %s_sw k=%0d got %b exp %b", nm, k, sw_a, e.sw);
      end
      if (busy_a !== e.busy) begin
        n_fail++; $display("FAIL %s_busy k=%0d got %b exp %b",
                            nm, k, busy_a, e.busy);
      end
      if (done_a !== e.done) begin
        n_fail++; $display("FAIL %s_done k=%0d got %b exp %b",
                            nm, k, done_a, e.done);
      end
      k++;
    end
  endtask

  task automatic test_clean;
    exp_t e;
    int k;
    @(negedge clk);
    lvl_c = 1'b1;
    push_trace(1'b0, 0, 3, 4, 1'b0, 16'h0, 2);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (sw_c !== e.sw) begin
        n_fail++; $display("FAIL clean_sw k=%0d got %b exp %b", k, sw_c, e.sw);
      end
      if (busy_c !== e.busy) begin
        n_fail++; $display("FAIL clean_busy k=%0d got %b exp %b",
                            k, busy_c, e.busy);
      end
      if (done_c !== e.done) begin
        n_fail++; $display("FAIL clean_done k=%0d got %b exp %b",
                            k, done_c, e.done);
      end
      k++;
    end
  endtask

  task automatic test_busy_input;
    exp_t e;
    int k;
    @(negedge clk);
    lvl_a = 1'b1;
    push_trace(1'b0, 2, 3, 5, 1'b0, 16'h0, 0);
    push_trace(1'b1, 2, 3, 5, 1'b0, 16'h0, 2);
    k = 0;
    while (q.size() > 0) begin
      if (k > 0) begin
        @(negedge clk);
        if (k == 4) lvl_a = 1'b0;
        if (k == 6) lvl_a = 1'b1;
        if (k == 14) lvl_a = 1'b0;
      end
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_chk += 3;
      if (sw_a !== e.sw) begin
        n_fail++; $display("FAIL busyin_sw k=%0d got %b exp %b", k, sw_a, e.sw);
      end
      if (busy_a !== e.busy) begin
        n_fail++; $display("FAIL busyin_busy k=%0d got %b exp %b",
                            k, busy_a, e.busy);
      end
      if (done_a !== e.done) begin
        n_fail++; $display("FAIL busyin_done k=%0d got %b exp %b",
                            k, done_a, e.done);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    lvl_a = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_chk += 2;
    if (sw_a !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_sw got %b exp 0", sw_a);
    end
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy_a);
    end
    lvl_a = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      n_chk++;
      if ({sw_a, busy_a, done_a} !== 3'b000) begin
        n_fail++; $display("FAIL rstmid_after got %b%b%b exp 000",
                            sw_a, busy_a, done_a);
      end
    end
  endtask

  task automatic test_jitter;
    exp_t e;
    logic start, prev;
    int k, last, gap;
    for (int t = 0; t < 2; t++) begin
      start = (t == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      lvl_j = ~start;
      push_trace(start, 3, 2, 3, 1'b1, m_lfsr, 2);
      prev = start;
      last = -1;
      k = 0;
      while (q.size() > 0) begin
        @(posedge clk);
        #1;
        e = q.pop_front();
        n_chk += 3;
        if (sw_j !== e.sw) begin
          n_fail++; $display("FAIL jit_sw t=%0d k=%0d got %b exp %b",
                              t, k, sw_j, e.sw);
        end
        if (busy_j !== e.busy) begin
          n_fail++; $display("FAIL jit_busy t=%0d k=%0d got %b exp %b",
                              t, k, busy_j, e.busy);
        end
        if (done_j !== e.done) begin
          n_fail++; $display("FAIL jit_done t=%0d k=%0d got %b exp %b",
                              t, k, done_j, e.done);
        end
        if (sw_j !== prev) begin
          if (last >= 0) begin
            gap = k - last;
            n_chk++;
            if (gap < 2 || gap > 5) begin
              n_fail++; $display("FAIL jit_gap t=%0d k=%0d got %0d exp 2..5",
                                  t, k, gap);
            end
          end
          last = k;
          prev = sw_j;
        end
        k++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic(1'b0, "basic");
    test_basic(1'b1, "return");
    test_clean;
    test_busy_input;
    test_reset_mid;
    test_jitter;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
